// File: rtl/vram_arbiter.sv
// Purpose: shares one single-port video RAM between a video fetcher and a CPU,
//   with a one-entry posted write buffer and a starvation guard for the CPU.
// Latency: video/CPU reads return data one clock after their slot is granted;
//   a CPU write is acknowledged in the clock it is presented when the buffer is empty.
// Backpressure: cpu_wait_n is low while a CPU access is pending; video has no
//   backpressure and is told about a lost slot through vid_miss.
// Ports:
//   clock, reset (async, active-low), ce (one arbitration slot per ce=1 clock)
//   vid_req/vid_a -> vid_d/vid_ack/vid_miss   video fetch side
//   cpu_req/cpu_we/cpu_a/cpu_di -> cpu_do/cpu_ack/cpu_wait_n   CPU side
//   ram_a/ram_we/ram_di -> ram_do   single-port RAM, read data valid one clock after ram_a
module vram_arbiter #(
  parameter int STARVE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        vid_req,
  input  logic [13:0] vid_a,
  output logic [7:0]  vid_d,
  output logic        vid_ack,
  output logic        vid_miss,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_a,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  output logic [13:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_di,
  input  logic [7:0]  ram_do
);

  typedef enum logic [1:0] {IDLE, VID, CPU_RD, WB_DRAIN} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  state_t      state, nextState, grant;
  logic        slotLast;   // the previous clock was a slot, so state holds a fresh grant
  logic        wbValid;
  logic [13:0] wbA;
  logic [7:0]  wbD;
  logic [3:0]  starveCnt;
  logic        missPend;
  logic        ackReg;     // registered part of cpu_ack (reads and buffer hits)

  logic cpuRead, cpuBusy, wbHit, rdHit, rdPend, cpuWant, forced, wrAccept;
  logic vidCapture, cpuCapture;

  assign vidCapture = slotLast && (state == VID);
  assign cpuCapture = slotLast && (state == CPU_RD);

  // A read already granted or just acknowledged must not be granted again
  // while the CPU still holds cpu_req for the ack clock.
  assign cpuRead  = cpu_req && !cpu_we;
  assign cpuBusy  = cpuCapture || ackReg;
  assign wbHit    = wbValid && (cpu_a == wbA);
  assign rdHit    = cpuRead && wbHit && !cpuBusy;
  assign rdPend   = cpuRead && !wbHit && !cpuBusy;
  assign cpuWant  = rdPend || wbValid;
  assign forced   = cpuWant && (starveCnt == STARVE_MAX);
  assign wrAccept = ce && cpu_req && cpu_we && !wbValid && !ackReg;

  assign cpu_ack    = ackReg || wrAccept;
  assign cpu_wait_n = !(cpu_req && !ackReg && !wrAccept);

  // Slot priority. A forced CPU slot drains the buffer first so a pending
  // read can never overtake an older posted write.
  always_comb begin
    grant     = IDLE;
    nextState = state;
    if (forced) begin
      grant = wbValid ? WB_DRAIN : CPU_RD;
    end else if (vid_req) begin
      grant = VID;
    end else if (wbValid) begin
      grant = WB_DRAIN;
    end else if (rdPend) begin
      grant = CPU_RD;
    end
    if (ce) begin
      nextState = grant;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      slotLast <= 1'b0;
    end else begin
      state    <= nextState;
      slotLast <= ce;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbValid   <= 1'b0;
      wbA       <= '0;
      wbD       <= '0;
      starveCnt <= '0;
      missPend  <= 1'b0;
      ackReg    <= 1'b0;
      vid_d     <= '0;
      vid_ack   <= 1'b0;
      vid_miss  <= 1'b0;
      cpu_do    <= '0;
      ram_a     <= '0;
      ram_we    <= 1'b0;
      ram_di    <= '0;
    end else begin
      // Pulses and captures run every clock so they stay one clock wide
      // even when the following clock is not a slot.
      ram_we   <= ce && (grant == WB_DRAIN);
      vid_ack  <= vidCapture;
      vid_miss <= missPend;
      missPend <= ce && forced && vid_req;
      ackReg   <= cpuCapture || (ce && rdHit);

      if (vidCapture) begin
        vid_d <= ram_do;
      end
      if (cpuCapture) begin
        cpu_do <= ram_do;
      end else if (ce && rdHit) begin
        cpu_do <= wbD;
      end

      if (ce) begin
        case (grant)
          VID:      ram_a <= vid_a;
          CPU_RD:   ram_a <= cpu_a;
          WB_DRAIN: begin
            ram_a   <= wbA;
            ram_di  <= wbD;
            wbValid <= 1'b0;
          end
          default:  ;
        endcase
        if ((grant == CPU_RD) || (grant == WB_DRAIN)) begin
          starveCnt <= '0;
        end else if ((grant == VID) && cpuWant && (starveCnt != STARVE_MAX)) begin
          starveCnt <= starveCnt + 4'd1;
        end
      end

      // Never coincides with a drain: acceptance needs an empty buffer.
      if (wrAccept) begin
        wbValid <= 1'b1;
        wbA     <= cpu_a;
        wbD     <= cpu_di;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose: directed and randomized checks of vram_arbiter against a RAM model,
//   a shadow memory of acknowledged CPU writes and a fixed fill pattern for video.
// Latency/backpressure: inputs change 1 time unit after a rising edge, outputs are sampled on the falling edge.
module tb_vram_arbiter;

  localparam int BOUND = 120;

  logic        clock, reset, ce;
  logic        vid_req, vid_ack, vid_miss;
  logic [13:0] vid_a;
  logic [7:0]  vid_d;
  logic        cpu_req, cpu_we, cpu_ack, cpu_wait_n;
  logic [13:0] cpu_a;
  logic [7:0]  cpu_di, cpu_do;
  logic [13:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_di, ram_do;

  int nChk = 0;
  int nFail = 0;

  vram_arbiter #(.STARVE(4)) dut (
    .clock(clock), .reset(reset), .ce(ce),
    .vid_req(vid_req), .vid_a(vid_a), .vid_d(vid_d), .vid_ack(vid_ack), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] fill(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // RAM model: the registered ram_a is the array address, so read data
  // follows one clock after the arbiter issues the address.
  logic [7:0] mem [0:16383];
  logic       memClr;
  assign ram_do = mem[ram_a];
  always @(posedge clock) begin
    if (memClr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= (i == 'h0123) ? 8'h5A : fill(14'(i));
    end else if (ram_we) begin
      mem[ram_a] <= ram_di;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextc();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic cpuIdle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_di = '0;
  endtask

  // random-phase reference state
  logic [7:0]  shadow [0:7];
  logic        act, actWe;
  logic [13:0] actA, curVidA;
  logic [7:0]  actD, expD;
  int          tw, n;
  logic        got, sawWe;

  initial begin
    reset = 1'b0; ce = 1'b1; vid_req = 1'b0; vid_a = '0; memClr = 1'b1;
    cpuIdle();
    nextc();
    memClr = 1'b0;
    samp();
    chk("rst_vid_d", vid_d, 0);       chk("rst_cpu_do", cpu_do, 0);
    chk("rst_ram_a", ram_a, 0);       chk("rst_ram_di", ram_di, 0);
    chk("rst_ram_we", ram_we, 0);     chk("rst_vid_ack", vid_ack, 0);
    chk("rst_vid_miss", vid_miss, 0); chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_wait_n", cpu_wait_n, 1);
    nextc();
    reset = 1'b1;
    nextc();

    // CPU read of 0x0123 with no video traffic
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0123;
    samp(); chk("rd_wait_low", cpu_wait_n, 0);
    nextc(); samp();
    chk("rd_ram_a", ram_a, 14'h0123); chk("rd_no_early_ack", cpu_ack, 0); chk("rd_wait_still", cpu_wait_n, 0);
    nextc(); samp();
    chk("rd_ack", cpu_ack, 1); chk("rd_data", cpu_do, 8'h5A); chk("rd_wait_high_at_ack", cpu_wait_n, 1);
    nextc(); cpuIdle(); samp();
    chk("rd_ack_one_clock", cpu_ack, 0);

    // write 0x0010=C3 then an immediate read of 0x0010 served by the buffer
    nextc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0010; cpu_di = 8'hC3;
    samp(); chk("hit_wr_ack", cpu_ack, 1); chk("hit_wr_wait", cpu_wait_n, 1);
    nextc(); cpu_we = 1'b0;
    samp(); chk("hit_rd_wait", cpu_wait_n, 0);
    nextc(); samp();
    chk("hit_ack_next_clock", cpu_ack, 1); chk("hit_data", cpu_do, 8'hC3);
    chk("hit_slot_is_drain", ram_we, 1);
    nextc(); cpuIdle(); samp();
    chk("hit_ack_done", cpu_ack, 0); chk("hit_drain_one_clock", ram_we, 0);

    // single write with empty buffer, drained in the next free slot
    nextc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0010; cpu_di = 8'hC3;
    samp(); chk("wr_ack_same", cpu_ack, 1); chk("wr_wait_high", cpu_wait_n, 1);
    nextc(); cpuIdle(); samp();
    chk("wr_no_we_yet", ram_we, 0);
    nextc(); samp();
    chk("wr_drain_we", ram_we, 1); chk("wr_drain_a", ram_a, 14'h0010); chk("wr_drain_d", ram_di, 8'hC3);
    nextc(); samp(); chk("wr_drain_done", ram_we, 0);

    // back-to-back writes: second waits for the first drain
    nextc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0020; cpu_di = 8'h11;
    samp(); chk("b2b_first_ack", cpu_ack, 1);
    nextc(); cpu_a = 14'h0021; cpu_di = 8'h22;
    samp(); chk("b2b_second_wait", cpu_wait_n, 0); chk("b2b_second_noack", cpu_ack, 0);
    nextc(); samp();
    chk("b2b_first_drain_a", ram_a, 14'h0020); chk("b2b_first_drain_we", ram_we, 1);
    chk("b2b_second_ack", cpu_ack, 1); chk("b2b_second_wait_high", cpu_wait_n, 1);
    nextc(); cpuIdle(); samp();
    nextc(); samp();
    chk("b2b_second_drain_a", ram_a, 14'h0021); chk("b2b_second_drain_d", ram_di, 8'h22);
    chk("b2b_second_drain_we", ram_we, 1);

    // video held high against a pending read: 4 video slots, forced CPU slot, video resumes
    nextc();
    vid_req = 1'b1; vid_a = 14'h2000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0123;
    n = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      nextc(); samp();
      if (cpu_ack) got = 1'b1;
      else n += int'(vid_ack);
    end
    chk("starve_cpu_served", got, 1); chk("starve_vid_grants", n, 4);
    chk("starve_vid_miss", vid_miss, 1); chk("starve_no_vid_ack", vid_ack, 0);
    chk("starve_cpu_data", cpu_do, 8'h5A);
    nextc(); cpuIdle(); samp();
    chk("starve_video_resumes", vid_ack, 1); chk("starve_vid_data", vid_d, fill(14'h2000));
    chk("starve_miss_one_clock", vid_miss, 0);
    nextc(); vid_req = 1'b0;

    // reset asserted while a write sits in the buffer
    nextc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0030; cpu_di = 8'h77;
    samp(); chk("rst_mid_wr_ack", cpu_ack, 1);
    nextc(); cpuIdle();
    reset = 1'b0;
    #1;
    chk("rst_mid_ram_we", ram_we, 0);   chk("rst_mid_cpu_do", cpu_do, 0);
    chk("rst_mid_vid_d", vid_d, 0);     chk("rst_mid_ram_a", ram_a, 0);
    chk("rst_mid_ram_di", ram_di, 0);   chk("rst_mid_cpu_ack", cpu_ack, 0);
    chk("rst_mid_wait_n", cpu_wait_n, 1);
    nextc(); nextc();
    reset = 1'b1;
    sawWe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nextc(); samp();
      sawWe |= ram_we;
    end
    chk("rst_mid_no_drain", sawWe, 0);
    chk("rst_mid_mem_kept", mem[14'h0030], fill(14'h0030));

    // no slots while ce=0
    nextc();
    ce = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0123;
    for (int i = 0; i < 3; i++) nextc();
    samp();
    chk("ce0_no_ack", cpu_ack, 0); chk("ce0_wait_low", cpu_wait_n, 0); chk("ce0_ram_a_held", ram_a, 0);
    nextc(); ce = 1'b1;
    nextc(); samp(); chk("ce1_ram_a", ram_a, 14'h0123);
    nextc(); samp(); chk("ce1_ack", cpu_ack, 1); chk("ce1_data", cpu_do, 8'h5A);
    nextc(); cpuIdle();

    // randomized traffic against the shadow memory and the video fill pattern
    for (int i = 0; i < 8; i++) shadow[i] = fill(14'(i));
    act = 1'b0; actWe = 1'b0; actA = '0; actD = '0; expD = '0; tw = 0;
    curVidA = 14'h2000; vid_a = curVidA;
    for (int c = 0; c < 3000; c++) begin
      nextc();
      ce = ($urandom_range(3) != 0);
      if ((c % 16) < 3) begin
        vid_req = 1'b0;
      end else begin
        if ((c % 16) == 3) begin
          curVidA = 14'h2000 + 14'($urandom_range(8191));
          vid_a = curVidA;
        end
        vid_req = 1'($urandom_range(1));
      end
      if (!act && ($urandom_range(1) == 1)) begin
        act = 1'b1; tw = 0;
        actWe = 1'($urandom_range(1));
        actA = 14'($urandom_range(7));
        actD = 8'($urandom_range(255));
        expD = shadow[actA[2:0]];
      end
      cpu_req = act; cpu_we = actWe; cpu_a = actA; cpu_di = actD;
      samp();
      if (vid_ack) chk("rnd_vid_data", vid_d, fill(curVidA));
      if (act) begin
        tw++;
        if (cpu_ack) begin
          chk("rnd_cpu_latency", 32'(tw <= BOUND), 1);
          if (actWe) shadow[actA[2:0]] = actD;
          else chk("rnd_cpu_rd_data", cpu_do, expD);
          act = 1'b0;
        end else if (tw > BOUND) begin
          chk("rnd_cpu_timeout", 32'(tw <= BOUND), 1);
          act = 1'b0;
        end
      end
    end
    nextc(); cpuIdle(); vid_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nFail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE, default 4, meaning the number of consecutive slots in which video may block a pending CPU access before the CPU is forced a slot (range 1-15).
REQ-002 SHALL have port clock  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ce  input  1  slot enable; one arbitration slot per clock with ce=1.
REQ-005 SHALL have port vid_req  input  1  video fetch request, sampled in slots.
REQ-006 SHALL have port vid_a  input  14  video fetch address.
REQ-007 SHALL have port vid_d  output  8  video fetch data, registered.
REQ-008 SHALL have port vid_ack  output  1  one-clock pulse when vid_d is updated.
REQ-009 SHALL have port vid_miss  output  1  one-clock pulse when a video request lost its slot to the CPU.
REQ-010 SHALL have port cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-011 SHALL have port cpu_we  input  1  1=write, 0=read; stable while cpu_req is high.
REQ-012 SHALL have port cpu_a  input  14  CPU address.
REQ-013 SHALL have port cpu_di  input  8  CPU write data.
REQ-014 SHALL have port cpu_do  output  8  CPU read data, registered.
REQ-015 SHALL have port cpu_ack  output  1  one-clock pulse completing a CPU access.
REQ-016 SHALL have port cpu_wait_n  output  1  low while cpu_req is pending and not yet acknowledged.
REQ-017 SHALL have port ram_a  output  14  single-port RAM address, registered.
REQ-018 SHALL have port ram_we  output  1  RAM write strobe, registered, one clock wide.
REQ-019 SHALL have port ram_di  output  8  RAM write data, registered.
REQ-020 SHALL have port ram_do  input  8  RAM read data; synchronous, valid one clock after ram_a.

Function
REQ-021 SHALL keep a one-entry posted write buffer (wb_valid, wb_a, wb_d).
REQ-022 SHALL run the FSM states IDLE, VID, CPU_RD and WB_DRAIN; the state is re-evaluated only in clocks with ce=1 and returns to IDLE after one slot.
REQ-023 SHALL grant each slot by priority: (1) CPU forced, when starve_cnt=STARVE and a CPU read or buffer drain is pending; (2) video, when vid_req=1; (3) WB_DRAIN, when wb_valid=1; (4) CPU_RD, when a read is pending and wb_valid=0.
REQ-024 SHALL register ram_a, ram_we and ram_di in the granting clock; ram_we=1 only in WB_DRAIN.
REQ-025 SHALL, one clock after a VID grant, latch ram_do into vid_d and pulse vid_ack.
REQ-026 SHALL, one clock after a CPU_RD grant, latch ram_do into cpu_do and pulse cpu_ack.
REQ-027 SHALL accept a CPU write (cpu_req=1, cpu_we=1) while wb_valid=0 immediately: load the buffer, pulse cpu_ack in the same clock and keep cpu_wait_n high.
REQ-028 SHALL hold a CPU write with wb_valid=1, keeping cpu_wait_n low until the drain completes, and SHALL accept it in the clock after the drain slot.
REQ-029 SHALL serve a CPU read that hits the buffer (wb_valid=1, cpu_a=wb_a) from wb_d, with cpu_ack in the next clock and no RAM slot.
REQ-030 SHALL serve a CPU read that misses a full buffer only after the drain, preserving write-before-read order.
REQ-031 SHALL increment starve_cnt (saturating at STARVE) in each slot where a CPU read or drain is pending and video wins, and SHALL clear it on any CPU_RD or WB_DRAIN grant.
REQ-032 SHALL, on a forced CPU grant with vid_req=1, pulse vid_miss one clock later and leave vid_d unchanged.
REQ-033 SHALL drive cpu_wait_n = !(cpu_req && pending) combinationally from registered state, so that it is high in the cpu_ack clock.
REQ-034 SHALL hold all outputs and state unchanged in clocks with ce=0, except the one-clock-later data capture and ack pulses.
REQ-035 SHALL ignore a cpu_req that is dropped before cpu_ack, abandoning any read not yet granted; a posted buffer entry is never abandoned.

Reset
REQ-036 SHALL, with reset low, clear the FSM to IDLE and clear wb_valid, starve_cnt, vid_d, cpu_do, ram_a, ram_di, ram_we, vid_ack, vid_miss and cpu_ack to 0, and set cpu_wait_n to 1.
REQ-037 SHALL lose a buffered write and any in-flight access when reset is asserted mid-operation; no ram_we pulse occurs after reset asserts.

Verification
REQ-038 SHALL cover: ce every clock, vid_req=0, CPU read a=0x0123 with RAM holding 0x5A -> ram_a=0x0123 one clock after the grant, cpu_do=0x5A, and cpu_ack two clocks after cpu_req.
REQ-039 SHALL cover: CPU write a=0x0010 d=0xC3 with buffer empty -> cpu_ack in the same clock with cpu_wait_n high, then ram_we=1, ram_a=0x0010, ram_di=0xC3 in the next free slot.
REQ-040 SHALL cover: a write followed at once by a read of 0x0010 -> cpu_do=0xC3 from the buffer, and no RAM read is issued for the read.
REQ-041 SHALL cover: vid_req held high with a CPU read pending and STARVE=4 -> 4 VID grants, then 1 CPU_RD grant with vid_miss pulsed, then video resumes.
REQ-042 SHALL cover: two back-to-back writes -> the second shows cpu_wait_n low until after the first drain, then is accepted.
REQ-043 SHALL cover: reset pulsed low while wb_valid=1 -> outputs at their reset values and no subsequent ram_we.
